// File: rtl/perip_bridge.sv
// Core data-port to peripheral bridge: one request at a time, one-hot slot decode,
// a single response pulse per accepted request, and error completion for unmapped addresses.
module perip_bridge #(
  parameter int          NSLV    = 4,
  parameter logic [3:0]  BASE_HI = 4'h1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic [NSLV-1:0]      per_wen_o,
  output logic [31:0]          per_waddr_o,
  output logic [31:0]          per_wdata_o,
  output logic [31:0]          per_raddr_o,
  input  logic [NSLV*32-1:0]   per_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR, RD0, RD1, ERR} state_t;

  state_t          state;
  logic [3:0]      slot_q;
  logic            hit;
  logic [NSLV-1:0] wen_dec;
  logic [31:0]     rd_sel;

  // Extended to 5 bits so NSLV=16 compares correctly against a 4-bit slot field.
  assign hit   = (addr_i[31:28] == BASE_HI) && ({1'b0, addr_i[15:12]} < 5'(NSLV));
  assign gnt_o = rst_n_i && req_i && (state == IDLE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wen_dec = '0;
    rd_sel  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (addr_i[15:12] == 4'(k)) wen_dec[k] = 1'b1;
      if (slot_q == 4'(k))        rd_sel     = per_rdata_i[32*k +: 32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      slot_q      <= '0;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      per_wen_o   <= '0;
      per_waddr_o <= '0;
      per_wdata_o <= '0;
      per_raddr_o <= '0;
    end else begin
      // Response and write-enable are single-cycle pulses unless re-armed below.
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      per_wen_o <= '0;
      case (state)
        IDLE: begin
          if (req_i) begin
            slot_q <= addr_i[15:12];
            if (!hit) begin
              state    <= ERR;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= '0;
            end else if (we_i) begin
              state       <= WR;
              per_wen_o   <= wen_dec;
              per_waddr_o <= addr_i;
              per_wdata_o <= wdata_i;
              rvalid_o    <= 1'b1;
            end else begin
              state       <= RD0;
              per_raddr_o <= addr_i;
            end
          end
        end
        RD0: begin
          rdata_o  <= rd_sel;
          rvalid_o <= 1'b1;
          state    <= RD1;
        end
        WR, RD1, ERR: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perip_bridge.sv
// Directed bench for perip_bridge: reset, write/read hits, unmapped accesses,
// back-to-back throughput, reset mid-read and idle stability.
module tb_perip_bridge;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         req_i;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic         gnt_o;
  logic         rvalid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic [3:0]   per_wen_o;
  logic [31:0]  per_waddr_o;
  logic [31:0]  per_wdata_o;
  logic [31:0]  per_raddr_o;
  logic [127:0] per_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perip_bridge #(.NSLV(4), .BASE_HI(4'h1)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .per_wen_o  (per_wen_o),
    .per_waddr_o(per_waddr_o),
    .per_wdata_o(per_wdata_o),
    .per_raddr_o(per_raddr_o),
    .per_rdata_i(per_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs change and outputs are sampled 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Held-request stimulus: three writes then three reads to slots 0/1/3.
  logic [31:0] t_addr [6] = '{32'h1000_0010, 32'h1000_1020, 32'h1000_3030,
                              32'h1000_0040, 32'h1000_1050, 32'h1000_3060};
  logic [31:0] t_data [6] = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 0, 0, 0};
  logic        t_we   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] e_wen  [6] = '{32'h1, 32'h2, 32'h8, 0, 0, 0};
  logic [31:0] e_rd   [6] = '{0, 0, 0, 32'h1111_0000, 32'h2222_1111, 32'h4444_3333};
  int          e_gnt  [6] = '{0, 2, 4, 6, 9, 12};
  int          e_rsp  [6] = '{1, 3, 5, 8, 11, 14};

  initial begin
    int idx;
    int rsp;
    int gnt_cyc [6];
    int rsp_cyc [6];

    per_rdata_i = {32'h4444_3333, 32'hDEAD_BEEF, 32'h2222_1111, 32'h1111_0000};
    rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) cyc();

    // Reset: no grant while held in reset, registered outputs cleared.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1000_0004;
    #1 check("gnt_in_reset", gnt_o, 0);
    req_i = 1'b0;
    cyc();
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_wen", per_wen_o, 0);
    check("rst_waddr", per_waddr_o, 0);
    check("rst_wdata", per_wdata_o, 0);
    check("rst_raddr", per_raddr_o, 0);
    rst_n_i = 1'b1;
    cyc();

    // 1: write hit to slot 0.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1000_0004; wdata_i = 32'h0000_000A;
    #1 check("wr_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    check("wr_wen", per_wen_o, 32'h1);
    check("wr_waddr", per_waddr_o, 32'h1000_0004);
    check("wr_wdata", per_wdata_o, 32'h0000_000A);
    check("wr_rvalid", rvalid_o, 1);
    check("wr_err", err_o, 0);
    cyc();
    check("wr_wen_clear", per_wen_o, 0);
    check("wr_rvalid_clear", rvalid_o, 0);

    // 2: read hit from slot 2.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1000_2000;
    #1 check("rd_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    check("rd_raddr", per_raddr_o, 32'h1000_2000);
    check("rd_no_early_rvalid", rvalid_o, 0);
    cyc();
    check("rd_rvalid", rvalid_o, 1);
    check("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    check("rd_err", err_o, 0);
    cyc();
    check("rd_rvalid_clear", rvalid_o, 0);
    check("rd_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // 3a: write outside the peripheral region.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h2000_0000; wdata_i = 32'h55;
    #1 check("miss_wr_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    check("miss_wr_rvalid", rvalid_o, 1);
    check("miss_wr_err", err_o, 1);
    check("miss_wr_rdata", rdata_o, 0);
    check("miss_wr_wen", per_wen_o, 0);
    cyc();
    check("miss_wr_rvalid_clear", rvalid_o, 0);
    check("miss_wr_wen_after", per_wen_o, 0);

    // 3b: read of slot 5, beyond NSLV.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1000_5000;
    #1 check("miss_rd_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    check("miss_rd_rvalid", rvalid_o, 1);
    check("miss_rd_err", err_o, 1);
    check("miss_rd_rdata", rdata_o, 0);
    check("miss_rd_wen", per_wen_o, 0);
    cyc();
    check("miss_rd_rvalid_clear", rvalid_o, 0);

    // 4: request held high across three writes and three reads.
    idx = 0;
    rsp = 0;
    for (int c = 0; c < 15; c++) begin
      if (idx < 6) begin
        req_i = 1'b1; we_i = t_we[idx]; addr_i = t_addr[idx]; wdata_i = t_data[idx];
      end else begin
        req_i = 1'b0;
      end
      #1;
      if (rvalid_o) begin
        if (rsp < 6) begin
          rsp_cyc[rsp] = c;
          check("hold_rsp_err", err_o, 0);
          if (t_we[rsp]) begin
            check("hold_rsp_wen", per_wen_o, e_wen[rsp]);
            check("hold_rsp_waddr", per_waddr_o, t_addr[rsp]);
          end else begin
            check("hold_rsp_rdata", rdata_o, e_rd[rsp]);
          end
        end
        rsp++;
      end
      if (gnt_o && idx < 6) begin
        gnt_cyc[idx] = c;
        idx++;
      end
      cyc();
    end
    req_i = 1'b0;
    check("hold_gnt_count", idx, 6);
    check("hold_rsp_count", rsp, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < idx) check("hold_gnt_cycle", gnt_cyc[i], e_gnt[i]);
      if (i < rsp) check("hold_rsp_cycle", rsp_cyc[i], e_rsp[i]);
    end

    // 5: reset one cycle after a read is accepted drops it.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1000_1000;
    #1 check("rstmid_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0; rst_n_i = 1'b0;
    check("rstmid_no_rvalid_t1", rvalid_o, 0);
    cyc();
    rst_n_i = 1'b1;
    check("rstmid_rvalid", rvalid_o, 0);
    check("rstmid_err", err_o, 0);
    check("rstmid_rdata", rdata_o, 0);
    check("rstmid_wen", per_wen_o, 0);
    check("rstmid_waddr", per_waddr_o, 0);
    check("rstmid_wdata", per_wdata_o, 0);
    check("rstmid_raddr", per_raddr_o, 0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1000_3008; wdata_i = 32'h77;
    #1 check("rstmid_new_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    check("rstmid_new_wen", per_wen_o, 32'h8);
    check("rstmid_new_rvalid", rvalid_o, 1);
    check("rstmid_new_waddr", per_waddr_o, 32'h1000_3008);
    check("rstmid_new_wdata", per_wdata_o, 32'h77);
    cyc();
    check("rstmid_new_wen_clear", per_wen_o, 0);

    // 6: idle for ten cycles; loaded values hold.
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("idle_gnt", gnt_o, 0);
      check("idle_rvalid", rvalid_o, 0);
      check("idle_wen", per_wen_o, 0);
      check("idle_waddr", per_waddr_o, 32'h1000_3008);
      check("idle_wdata", per_wdata_o, 32'h77);
      check("idle_rdata", rdata_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
